// File: rtl/wb_decode_mux_n_pkg.sv
// Shared types and default SoC address map for the Wishbone decoder/mux.
// Slave 0 occupies the least-significant word of the packed base/mask vectors.
package wb_decode_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // dmem, imem, uart, gpio, spi
  localparam logic [5*32-1:0] DEF_BASE = {
    32'h2000_0200, 32'h2000_0100, 32'h2000_0000, 32'h0001_0000, 32'h0000_0000
  };
  localparam logic [5*32-1:0] DEF_MASK = {
    32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_E000, 32'hFFFF_E000
  };

endpackage

// File: rtl/wb_decode_mux_n_addr_decode.sv
// Combinational base/mask address matcher; the lowest matching slave index wins.
// Produces a one-hot hit vector and a miss flag when nothing matches.
module wb_addr_decode #(
  parameter int NUM_SLAVES = 5,
  parameter int ADDR_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0
) (
  input  logic [ADDR_W-1:0]     adr,
  output logic [NUM_SLAVES-1:0] hit,
  output logic                  miss
);

  logic found;

  always_comb begin
    hit   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!found &&
          ((adr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) ==
           (SLAVE_BASE[i*ADDR_W +: ADDR_W] & SLAVE_MASK[i*ADDR_W +: ADDR_W]))) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
    end
    miss = !found;
  end

endmodule

// File: rtl/wb_decode_mux_n.sv
// One-master, N-slave Wishbone classic decoder with registered response mux and stall watchdog.
// Define WB_DECODE_FAULT_LOG_EN to build the fault pulse/address/counter registers.
module wb_decode_mux_n
  import wb_decode_pkg::*;
#(
  parameter int NUM_SLAVES     = 5,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = DEF_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = DEF_MASK
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_i,
  input  logic [ADDR_W-1:0]                m_adr_i,
  input  logic [DATA_W-1:0]                m_dat_i,
  input  logic [DATA_W/8-1:0]              m_sel_i,
  input  logic                             m_we_i,
  input  logic                             m_cyc_i,
  input  logic                             m_stb_i,
  output logic [DATA_W-1:0]                m_dat_o,
  output logic                             m_ack_o,
  output logic                             m_err_o,
  output logic [NUM_SLAVES*ADDR_W-1:0]     s_adr_o,
  output logic [NUM_SLAVES*DATA_W-1:0]     s_dat_o,
  output logic [NUM_SLAVES*(DATA_W/8)-1:0] s_sel_o,
  output logic [NUM_SLAVES-1:0]            s_we_o,
  output logic [NUM_SLAVES-1:0]            s_cyc_o,
  output logic [NUM_SLAVES-1:0]            s_stb_o,
  input  logic [NUM_SLAVES*DATA_W-1:0]     s_dat_i,
  input  logic [NUM_SLAVES-1:0]            s_ack_i,
  input  logic [NUM_SLAVES-1:0]            s_err_i,
  output logic                             fault_o,
  output logic [ADDR_W-1:0]                fault_adr_o,
  output logic [7:0]                       fault_cnt_o
);

  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t                  state, state_nxt;
  logic [NUM_SLAVES-1:0]   sel_q, hit;
  logic                    miss, req, sel_ack, sel_err, timeout;
  logic                    ack_nxt, err_nxt, load_sel;
  logic [31:0]             timer;
  logic [DATA_W-1:0]       sel_dat;

  wb_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .adr  (m_adr_i),
    .hit  (hit),
    .miss (miss)
  );

  assign req     = m_cyc_i & m_stb_i;
  assign sel_ack = |(s_ack_i & sel_q);
  assign sel_err = |(s_err_i & sel_q);
  assign timeout = (TIMEOUT_CYCLES != 0) && (timer == TIMER_LAST);

  assign s_adr_o = {NUM_SLAVES{m_adr_i}};
  assign s_dat_o = {NUM_SLAVES{m_dat_i}};
  assign s_sel_o = {NUM_SLAVES{m_sel_i}};
  assign s_we_o  = {NUM_SLAVES{m_we_i}};
  assign s_cyc_o = (state == ACTIVE) ? ({NUM_SLAVES{m_cyc_i}} & sel_q) : '0;
  assign s_stb_o = (state == ACTIVE) ? ({NUM_SLAVES{m_stb_i}} & sel_q) : '0;

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) sel_dat = sel_dat | s_dat_i[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    load_sel  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (miss) begin
            state_nxt = DONE;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = ACTIVE;
            load_sel  = 1'b1;
          end
        end
      end
      ACTIVE: begin
        // Abort beats any response; error beats a simultaneous ack.
        if (!m_cyc_i) begin
          state_nxt = IDLE;
        end else if (sel_err || timeout) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end else if (sel_ack) begin
          state_nxt = DONE;
          ack_nxt   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered response stage
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      m_dat_o <= '0;
      timer   <= '0;
      sel_q   <= '0;
    end else begin
      state   <= state_nxt;
      m_ack_o <= ack_nxt;
      m_err_o <= err_nxt;
      if (ack_nxt) m_dat_o <= sel_dat;
      if (load_sel) sel_q <= hit;
      timer   <= (state == ACTIVE) ? timer + 32'd1 : '0;
    end
  end

`ifdef WB_DECODE_FAULT_LOG_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic fault_nxt;

  assign fault_nxt = ((state == IDLE) && req && miss) ||
                     ((state == ACTIVE) && m_cyc_i && !sel_err && !sel_ack && timeout);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      fault_o     <= 1'b0;
      fault_adr_o <= '0;
      fault_cnt_o <= '0;
    end else begin
      fault_o <= fault_nxt;
      if (fault_nxt) begin
        fault_adr_o <= m_adr_i;
        fault_cnt_o <= sat_inc8(fault_cnt_o);
      end
    end
  end
`else
  assign fault_o     = 1'b0;
  assign fault_adr_o = '0;
  assign fault_cnt_o = '0;
`endif

endmodule

// File: doc/wb_decode_mux_n.md
Name: wb_decode_mux_n

Overview:
- Parametrised one-master, N-slave Wishbone classic decoder and response multiplexer.
- Sits between wishbone_controller and the peripherals: data_mem, imem, uart_top, gpio_top, spi.
- Adds a registered transaction FSM, per-slave base/mask decode, and an error response for unmapped addresses.
- Adds a stall watchdog that terminates hung slave cycles with an error.

Parameters:
- NUM_SLAVES, 5, number of slave ports.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 255, ACTIVE cycles without ack/err before forced error; 0 disables the watchdog.
- SLAVE_BASE, wb_decode_pkg::DEF_BASE, packed NUM_SLAVES*ADDR_W base addresses.
- SLAVE_MASK, wb_decode_pkg::DEF_MASK, packed NUM_SLAVES*ADDR_W match masks.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset; synchronous, active-high
- m_adr_i  in  ADDR_W  master address
- m_dat_i  in  DATA_W  master write data
- m_sel_i  in  DATA_W/8  byte selects
- m_we_i  in  1  write enable
- m_cyc_i  in  1  cycle
- m_stb_i  in  1  strobe
- m_dat_o  out  DATA_W  read data (registered)
- m_ack_o  out  1  acknowledge (registered)
- m_err_o  out  1  error (registered)
- s_adr_o  out  NUM_SLAVES*ADDR_W  broadcast address
- s_dat_o  out  NUM_SLAVES*DATA_W  broadcast write data
- s_sel_o  out  NUM_SLAVES*DATA_W/8  broadcast byte selects
- s_we_o  out  NUM_SLAVES  broadcast write enable
- s_cyc_o  out  NUM_SLAVES  per-slave cycle
- s_stb_o  out  NUM_SLAVES  per-slave strobe
- s_dat_i  in  NUM_SLAVES*DATA_W  slave read data
- s_ack_i  in  NUM_SLAVES  slave ack
- s_err_i  in  NUM_SLAVES  slave error
- fault_o  out  1  one-cycle pulse on decode miss or timeout
- fault_adr_o  out  ADDR_W  last faulting address
- fault_cnt_o  out  8  fault counter

Behaviour:
- Reset: wb_rst_i=1 at a clock edge forces state IDLE and clears all registered outputs: m_ack_o, m_err_o, m_dat_o, fault_o, fault_adr_o, fault_cnt_o, timer, sel_q. Applies mid-transaction; no ack is issued afterwards.
- Decode: slave i matches when (m_adr_i & MASK[i]) == (BASE[i] & MASK[i]). The lowest index wins on overlap. No match is a miss.
- FSM states: IDLE, ACTIVE, DONE.
- IDLE -> ACTIVE: m_cyc_i & m_stb_i with a hit; latch sel_q (one-hot); timer cleared.
- IDLE -> DONE: m_cyc_i & m_stb_i with a miss; m_err_o=1 in DONE; fault_o pulses; fault_adr_o=m_adr_i.
- ACTIVE slave drive: s_cyc_o[i]=m_cyc_i & sel_q[i]; s_stb_o[i]=m_stb_i & sel_q[i]. All other slaves see 0.
- Broadcast signals (s_adr_o, s_dat_o, s_sel_o, s_we_o) follow the master combinationally in every state.
- ACTIVE -> DONE on the selected s_ack_i: capture s_dat_i of the selected slave into m_dat_o; m_ack_o=1.
- ACTIVE -> DONE on the selected s_err_i: m_err_o=1. If ack and err are simultaneous, err wins.
- ACTIVE timeout: timer increments each ACTIVE cycle. When timer==TIMEOUT_CYCLES-1 with no response, go to DONE with m_err_o=1, fault_o pulse, fault_adr_o latched.
- ACTIVE abort: m_cyc_i low -> IDLE immediately, no ack/err, no fault.
- DONE: m_ack_o or m_err_o high for exactly one cycle; all s_stb_o/s_cyc_o low; next state IDLE unconditionally.
- Latency: a slave ack in cycle k gives m_ack_o in cycle k+1. Minimum request-to-ack is 2 cycles for a zero-wait slave.
- m_dat_o holds its last value between transactions. It is updated only on ack; writes also capture, and the value is don't-care.
- fault_cnt_o saturates at 255.

Optional Feature:
- Macro: WB_DECODE_FAULT_LOG_EN.
- Defined: fault_o, fault_adr_o and fault_cnt_o behave as specified above.
- Undefined: these ports are tied to 0 and no fault registers are synthesised. Decode-miss and timeout error responses remain unchanged.

Decomposition:
- Package wb_decode_pkg holds the state_t enum (IDLE, ACTIVE, DONE).
- It also holds DEF_BASE/DEF_MASK localparams for the SoC map: dmem 0x0000_0000/0xFFFF_E000, imem 0x0001_0000/0xFFFF_E000, uart 0x2000_0000/0xFFFF_FF00, gpio 0x2000_0100/0xFFFF_FF00, spi 0x2000_0200/0xFFFF_FF00.
- Sub-module: wb_addr_decode, the combinational priority matcher that outputs a one-hot hit vector plus a miss flag.

Test Plan:
- Zero-wait gpio slave: read 0x2000_0104 returning 0xCAFE_F00D -> only s_stb_o[3] asserted; m_ack_o 2 cycles after request; m_dat_o=0xCAFE_F00D.
- Unmapped address 0x4000_0000 -> no slave strobed; m_err_o pulses 1 cycle; fault_adr_o=0x4000_0000; fault_cnt_o=1.
- Slave never acks with TIMEOUT_CYCLES=8 -> m_err_o exactly 8 cycles after ACTIVE entry; s_stb_o drops in DONE; fault_cnt_o increments.
- Selected slave raises ack and err in the same cycle -> m_err_o=1, m_ack_o=0.
- wb_rst_i asserted in the 3rd ACTIVE cycle -> next cycle all outputs 0, state IDLE; a late slave ack produces no m_ack_o.
- Master drops m_cyc_i while ACTIVE -> immediate return to IDLE with no ack, err or fault. Run with WB_DECODE_FAULT_LOG_EN undefined and confirm the fault ports stay 0.
